// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32I pipeline: fetch FSM encoding, reset PC and the
// canonical NOP (addi x0,x0,0).
package rv32i_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_stage_pc_reg.sv
// Program counter for the fetch stage: redirect target beats increment beats hold.
import rv32i_pkg::*;

module pc_reg #(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        inc,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    logic [31:0] pc_r;
    logic [31:0] pc_next_s;

    assign pc       = pc_r;
    assign pc_plus4 = pc_r + 32'd4;

    // Next-PC select
    always_comb begin
        pc_next_s = pc_r;
        if (redirect_valid) begin
            pc_next_s = align_word(redirect_pc);
        end else if (inc) begin
            pc_next_s = pc_plus4;
        end else begin
            pc_next_s = pc_r;
        end
    end

    // PC register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= pc_next_s;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// RV32I instruction-fetch stage: single-outstanding imem requests, stall-aware
// output register towards IF/ID, and EX redirect/flush handling.
import rv32i_pkg::*;

module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = rv32i_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        valid_out,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic [31:0] pc4_out
);

    fetch_state_e state_r;
    logic         drop_r;
    logic [31:0]  hold_r;
    logic         valid_r;
    logic [31:0]  instr_r;
    logic [31:0]  pc_out_r;
    logic [31:0]  pc4_out_r;

    logic [31:0]  pc_s;
    logic [31:0]  pc_plus4_s;
    logic         out_free_s;
    logic         load_rsp_s;
    logic         load_hold_s;
    logic         load_s;
    logic [31:0]  load_data_s;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inc            (load_s),
        .pc             (pc_s),
        .pc_plus4       (pc_plus4_s)
    );

    assign imem_req_valid = (state_r == S_REQ);
    assign imem_addr      = pc_s;
    assign valid_out      = valid_r;
    assign instr_out      = instr_r;
    assign pc_out         = pc_out_r;
    assign pc4_out        = pc4_out_r;

    // Decide whether an instruction reaches the output register this cycle
    always_comb begin
        out_free_s  = ~stall | ~valid_r;
        load_rsp_s  = 1'b0;
        load_hold_s = 1'b0;
        if (redirect_valid) begin
            load_rsp_s  = 1'b0;
            load_hold_s = 1'b0;
        end else begin
            load_rsp_s  = (state_r == S_WAIT) & imem_rsp_valid & ~drop_r & out_free_s;
            load_hold_s = (state_r == S_HOLD) & ~stall;
        end
        load_s      = load_rsp_s | load_hold_s;
        load_data_s = load_hold_s ? hold_r : imem_rsp_data;
    end

    // Fetch FSM; drop marks an accepted request whose response must be discarded
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_REQ;
            drop_r  <= 1'b0;
            hold_r  <= 32'h0000_0000;
        end else begin
            case (state_r)
                S_REQ: begin
                    if (imem_req_ready) begin
                        state_r <= S_WAIT;
                        drop_r  <= redirect_valid;
                    end else begin
                        state_r <= S_REQ;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        drop_r <= 1'b0;
                        if (drop_r || redirect_valid || out_free_s) begin
                            state_r <= S_REQ;
                        end else begin
                            hold_r  <= imem_rsp_data;
                            state_r <= S_HOLD;
                        end
                    end else if (redirect_valid) begin
                        drop_r <= 1'b1;
                    end else begin
                        state_r <= S_WAIT;
                    end
                end
                S_HOLD: begin
                    if (redirect_valid || !stall) begin
                        state_r <= S_REQ;
                    end else begin
                        state_r <= S_HOLD;
                    end
                end
                default: begin
                    state_r <= S_REQ;
                    drop_r  <= 1'b0;
                end
            endcase
        end
    end

    // Output register towards IF/ID: flush, load, bubble or hold
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_r   <= 1'b0;
            instr_r   <= NOP_INSTR;
            pc_out_r  <= 32'h0000_0000;
            pc4_out_r <= 32'h0000_0000;
        end else if (redirect_valid) begin
            valid_r <= 1'b0;
            instr_r <= NOP_INSTR;
        end else if (load_s) begin
            valid_r   <= 1'b1;
            instr_r   <= load_data_s;
            pc_out_r  <= pc_s;
            pc4_out_r <= pc_plus4_s;
        end else if (!stall) begin
            valid_r <= 1'b0;
            instr_r <= NOP_INSTR;
        end else begin
            valid_r <= valid_r;
            instr_r <= instr_r;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: a scoreboard queue of expected instructions is
// filled when responses are driven and drained by a monitor watching valid_out.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        valid_out;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic [31:0] pc4_out;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    exp_t cur;
    logic hold_exp;

    if_fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .valid_out      (valid_out),
        .instr_out      (instr_out),
        .pc_out         (pc_out),
        .pc4_out        (pc4_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Outputs must hold across an edge where stall met a valid instruction and no redirect
    always @(posedge clk or posedge reset) begin
        if (reset) hold_exp <= 1'b0;
        else       hold_exp <= valid_out && stall && !redirect_valid;
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (valid_out) begin
                if (hold_exp) begin
                    check("hold_instr", instr_out, cur.instr);
                    check("hold_pc", pc_out, cur.pc);
                end else if (sb.size() == 0) begin
                    check("unexpected_valid", {31'd0, valid_out}, 32'd0);
                end else begin
                    cur = sb.pop_front();
                    check("instr_out", instr_out, cur.instr);
                    check("pc_out", pc_out, cur.pc);
                    check("pc4_out", pc4_out, cur.pc4);
                end
            end else begin
                check("bubble_instr", instr_out, NOP);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b0;
        redirect_valid = 1'b0;
    endtask

    task automatic check_req(input string tag, input logic [31:0] addr);
        check({tag, "_req_valid"}, {31'd0, imem_req_valid}, 32'd1);
        check({tag, "_addr"}, imem_addr, addr);
    endtask

    // One request/response pair with a one-cycle memory response
    task automatic fetch(input logic [31:0] addr, input logic [31:0] data);
        exp_t e;
        step();
        check_req("fetch", addr);
        imem_req_ready = 1'b1;
        step();
        check("wait_req_valid", {31'd0, imem_req_valid}, 32'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        e.instr = data;
        e.pc    = addr;
        e.pc4   = addr + 32'd4;
        sb.push_back(e);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_valid", {31'd0, valid_out}, 32'd0);
        check("rst_instr", instr_out, NOP);
        check("rst_pc_out", pc_out, 32'd0);
        check("rst_pc4_out", pc4_out, 32'd0);
        check_req("rst", 32'h0);
        reset = 1'b0;

        // Sequential fetch from reset
        fetch(32'h0000_0000, 32'h0010_0093);
        fetch(32'h0000_0004, 32'h0020_0113);
        fetch(32'h0000_0008, 32'h0030_0193);

        // Stall while a response arrives -> S_HOLD
        fetch(32'h0000_000C, 32'h0040_0213);
        step();
        stall = 1'b1;
        check_req("stall_req", 32'h0000_0010);
        imem_req_ready = 1'b1;
        step();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0050_0293;
        sb.push_back('{32'h0050_0293, 32'h0000_0010, 32'h0000_0014});
        step();
        check("hold_req_valid_a", {31'd0, imem_req_valid}, 32'd0);
        step();
        check("hold_req_valid_b", {31'd0, imem_req_valid}, 32'd0);
        stall = 1'b0;
        step();
        check_req("after_hold", 32'h0000_0014);

        // Redirect during S_WAIT
        imem_req_ready = 1'b1;
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        step();
        check("redir_valid_out", {31'd0, valid_out}, 32'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_0001;
        step();
        check_req("redir_wait", 32'h0000_0100);
        fetch(32'h0000_0100, 32'h0060_0313);

        // Redirect coincident with response while stalled
        step();
        stall = 1'b1;
        imem_req_ready = 1'b1;
        step();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_0002;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        step();
        stall = 1'b0;
        check("redir_stall_valid", {31'd0, valid_out}, 32'd0);
        check("redir_stall_instr", instr_out, NOP);
        check_req("redir_stall", 32'h0000_0200);
        fetch(32'h0000_0200, 32'h0070_0393);

        // imem not ready for 5 cycles
        for (int i = 0; i < 5; i++) begin
            step();
            check_req("not_ready", 32'h0000_0204);
        end
        fetch(32'h0000_0204, 32'h0080_0413);

        // Redirect to top of address space, pc+4 wraps
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        step();
        check_req("wrap", 32'hFFFF_FFFC);
        fetch(32'hFFFF_FFFC, 32'h0090_0493);
        fetch(32'h0000_0000, 32'h00A0_0513);

        // Redirect in S_REQ with request accepted the same cycle
        step();
        imem_req_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        step();
        check("req_redir_req_valid", {31'd0, imem_req_valid}, 32'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_0003;
        step();
        check_req("req_redir", 32'h0000_0300);
        fetch(32'h0000_0300, 32'h00B0_0593);

        // Asynchronous reset while in S_WAIT, late response ignored
        step();
        imem_req_ready = 1'b1;
        step();
        #2 reset = 1'b1;
        #1;
        check("arst_pc_out", pc_out, 32'd0);
        check("arst_pc4_out", pc4_out, 32'd0);
        check("arst_valid", {31'd0, valid_out}, 32'd0);
        check("arst_instr", instr_out, NOP);
        step();
        reset = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_0004;
        step();
        check("late_rsp_valid", {31'd0, valid_out}, 32'd0);
        check_req("post_reset", 32'h0000_0000);
        fetch(32'h0000_0000, 32'h00C0_0613);
        repeat (3) step();
        check("sb_drained", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
